// File: rtl/channel_rr_arbiter.sv
// Round-robin arbiter draining per-channel local FIFOs into one shared chip FIFO.
// One event per grant: arbitrate, strobe read, latch data, wait for ack.
module channel_rr_arbiter #(
  parameter int NUMCHANNELS = 64,
  parameter int WIDTH       = 64,
  parameter int IDW         = $clog2(NUMCHANNELS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUMCHANNELS-1:0] local_fifo_empty,
  input  logic [NUMCHANNELS-1:0] channel_mask,
  input  logic [WIDTH-2:0]       input_event [NUMCHANNELS],
  input  logic                   shared_fifo_full,
  input  logic                   fifo_ack,
  input  logic                   clear_count,
  output logic [NUMCHANNELS-1:0] read_local_fifo_n,
  output logic [WIDTH-2:0]       channel_event_out,
  output logic                   load_event,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy,
  output logic [15:0]            event_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  localparam logic [IDW-1:0] LAST_ID = IDW'(NUMCHANNELS - 1);

  logic [2:0]             state_q, state_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]         grant_q, grant_d;
  logic [WIDTH-2:0]       data_q, data_d;
  logic                   load_q, load_d;
  logic [15:0]            count_q, count_d;

  logic [NUMCHANNELS-1:0] eligible;
  logic [NUMCHANNELS-1:0] upper;
  logic [NUMCHANNELS-1:0] hi_req;
  logic                   any_elig;
  logic                   can_start;
  logic                   ack_hit;
  logic [IDW-1:0]         winner;

  function automatic logic [IDW-1:0] first_set(
    input logic [NUMCHANNELS-1:0] v
  );
    first_set = '0;
    for (int i = NUMCHANNELS - 1; i >= 0; i--) begin
      if (v[i]) first_set = IDW'(i);
    end
  endfunction

  assign eligible  = ~local_fifo_empty & ~channel_mask;
  assign any_elig  = |eligible;
  assign can_start = any_elig & ~shared_fifo_full;
  assign ack_hit   = (state_q == S_WAIT) & fifo_ack;

  // Requests at or above the pointer win first; otherwise wrap to the bottom.
  always_comb begin
    upper = '0;
    for (int i = 0; i < NUMCHANNELS; i++) begin
      upper[i] = (IDW'(i) >= rr_ptr_q);
    end
  end

  assign hi_req = eligible & upper;
  assign winner = (|hi_req) ? first_set(hi_req) : first_set(eligible);

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = can_start ? S_ARB : S_IDLE;
      S_ARB:   state_d = any_elig ? S_READ : S_IDLE;
      S_READ:  state_d = S_LATCH;
      S_LATCH: state_d = S_WAIT;
      S_WAIT: begin
        if (!fifo_ack)      state_d = S_WAIT;
        else if (can_start) state_d = S_ARB;
        else                state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    load_d   = (state_q == S_LATCH);
    if (state_q == S_ARB && any_elig) grant_d = winner;
    if (state_q == S_LATCH) data_d = input_event[grant_q];
    if (ack_hit) begin
      rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear_count)                        count_d = '0;
    else if (ack_hit && count_q != 16'hFFFF) count_d = count_q + 16'd1;
  end

  always_comb begin
    read_local_fifo_n = '1;
    if (state_q == S_READ) read_local_fifo_n[grant_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      load_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      load_q   <= load_d;
      count_q  <= count_d;
    end
  end

  assign channel_event_out = data_q;
  assign load_event        = load_q;
  assign grant_id          = grant_q;
  assign busy              = (state_q != S_IDLE);
  assign event_count       = count_q;

endmodule
